// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 Hz timing constants, helpers that derive
// totals and sync-window bounds from a timing set, and the coordinate type.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIPE_DLY = 0;

  // Total pixels per line / lines per frame.
  function automatic int timing_total(input int active, input int fp,
                                      input int sw, input int bp);
    return active + fp + sw + bp;
  endfunction

  // First count inside the sync pulse.
  function automatic int sync_lo(input int active, input int fp);
    return active + fp;
  endfunction

  // First count after the sync pulse.
  function automatic int sync_hi(input int active, input int fp, input int sw);
    return active + fp + sw;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: PIPE_DLY-deep shift register for {hsync, vsync, blank_b},
// advanced only on pixel ticks so the lag is counted in pixels. Stages reset
// to the inactive pattern (hsync=1, vsync=1, blank_b=0).
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   i_en       : pixel tick, shift enable
//   i_sync     : {hsync, vsync, blank_b} undelayed
//   o_sync     : {hsync, vsync, blank_b} delayed by PIPE_DLY ticks
module vga_sync_delay #(
  parameter int PIPE_DLY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [2:0] i_sync,
  output logic [2:0] o_sync
);

  localparam logic [2:0] SYNC_IDLE = 3'b110;

  generate
    if (PIPE_DLY == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, i_en};
      assign o_sync   = i_sync;
    end else begin : g_dly
      logic [2:0] r_stage [PIPE_DLY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DLY; i++) r_stage[i] <= SYNC_IDLE;
        end else if (i_en) begin
          r_stage[0] <= i_sync;
          for (int i = 1; i < PIPE_DLY; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_sync = r_stage[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from the system clock.
// A divider produces one pixel tick every CLK_DIV clocks; on each tick the
// h/v counters advance and the registered outputs load the decode of the
// count being entered, so x/y and the undelayed syncs always agree.
// Ports:
//   clk, rst_n    : system clock, async active-low reset
//   vga_clk       : pixel clock, rising edge mid-pixel
//   hsync, vsync  : active-low syncs (delayed PIPE_DLY ticks)
//   sync_b        : composite sync, tied low
//   blank_b       : 1 in visible region (delayed PIPE_DLY ticks)
//   x, y          : current pixel column / row
//   line_start    : one-clk pulse when x becomes 0
//   frame_start   : one-clk pulse when (x,y) becomes (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               vga_clk,
  output logic               hsync,
  output logic               vsync,
  output logic               sync_b,
  output logic               blank_b,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam coord_t H_MAX   = coord_t'(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam coord_t V_MAX   = coord_t'(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO   = coord_t'(sync_lo(H_ACTIVE, H_FP));
  localparam coord_t HS_HI   = coord_t'(sync_hi(H_ACTIVE, H_FP, H_SYNC));
  localparam coord_t VS_LO   = coord_t'(sync_lo(V_ACTIVE, V_FP));
  localparam coord_t VS_HI   = coord_t'(sync_hi(V_ACTIVE, V_FP, V_SYNC));

  logic [DIV_W-1:0] r_div;
  logic             r_vga_clk;
  logic             r_started;
  coord_t           r_hcnt;
  coord_t           r_vcnt;
  logic             r_hsync_raw;
  logic             r_vsync_raw;
  logic             r_blank_raw;
  logic             r_line_start;
  logic             r_frame_start;

  logic [DIV_W-1:0] w_div_next;
  logic             w_tick;
  coord_t           w_hnext;
  coord_t           w_vnext;
  logic [2:0]       w_sync_dly;

  assign w_tick     = (r_div == DIV_MAX);
  assign w_div_next = w_tick ? '0 : r_div + 1'b1;

  // Before the first tick the counters sit at (0,0); that first tick presents
  // (0,0) without advancing so the frame opens with a full pixel 0.
  always_comb begin
    w_hnext = r_hcnt;
    w_vnext = r_vcnt;
    if (r_started) begin
      if (r_hcnt == H_MAX) begin
        w_hnext = '0;
        w_vnext = (r_vcnt == V_MAX) ? '0 : r_vcnt + 1'b1;
      end else begin
        w_hnext = r_hcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_vga_clk     <= 1'b0;
      r_started     <= 1'b0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hsync_raw   <= 1'b1;
      r_vsync_raw   <= 1'b1;
      r_blank_raw   <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_next;
      r_vga_clk     <= (w_div_next >= DIV_HALF);
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_tick) begin
        r_started     <= 1'b1;
        r_hcnt        <= w_hnext;
        r_vcnt        <= w_vnext;
        r_blank_raw   <= (w_hnext < H_ACT_C) && (w_vnext < V_ACT_C);
        r_hsync_raw   <= !((w_hnext >= HS_LO) && (w_hnext < HS_HI));
        r_vsync_raw   <= !((w_vnext >= VS_LO) && (w_vnext < VS_HI));
        r_line_start  <= (w_hnext == '0);
        r_frame_start <= (w_hnext == '0) && (w_vnext == '0);
      end
    end
  end

  vga_sync_delay #(
    .PIPE_DLY (PIPE_DLY)
  ) u_sync_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_tick),
    .i_sync ({r_hsync_raw, r_vsync_raw, r_blank_raw}),
    .o_sync (w_sync_dly)
  );

  assign hsync       = w_sync_dly[2];
  assign vsync       = w_sync_dly[1];
  assign blank_b     = w_sync_dly[0];
  assign sync_b      = 1'b0;
  assign vga_clk     = r_vga_clk;
  assign x           = r_hcnt;
  assign y           = r_vcnt;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances share clock and reset --
// default timing (PIPE_DLY=0), default timing with PIPE_DLY=2, and a small
// timing set (CLK_DIV=4, 15x8 raster, PIPE_DLY=1) so whole frames fit in a
// short run. Expected outputs come from an edge-count model of the raster.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs, vs, bl, ls, fs, vc, sb;
  } obs_t;

  typedef struct packed {
    int   id;
    obs_t e;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] x [3];
  logic [9:0] y [3];
  logic hs [3], vs [3], bl [3], ls [3], fs [3], vc [3], sb [3];
  obs_t obs [3];

  // Timing of each instance, indexed 0..2.
  int cd  [3] = '{2, 2, 4};
  int ha  [3] = '{640, 640, 8};
  int hfp [3] = '{16, 16, 2};
  int hsw [3] = '{96, 96, 3};
  int hbp [3] = '{48, 48, 2};
  int va  [3] = '{480, 480, 4};
  int vfp [3] = '{10, 10, 1};
  int vsw [3] = '{2, 2, 2};
  int vbp [3] = '{33, 33, 1};
  int dly [3] = '{0, 2, 1};

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .vga_clk(vc[0]), .hsync(hs[0]), .vsync(vs[0]),
    .sync_b(sb[0]), .blank_b(bl[0]), .x(x[0]), .y(y[0]),
    .line_start(ls[0]), .frame_start(fs[0]));

  vga_timing_gen #(.PIPE_DLY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .vga_clk(vc[1]), .hsync(hs[1]), .vsync(vs[1]),
    .sync_b(sb[1]), .blank_b(bl[1]), .x(x[1]), .y(y[1]),
    .line_start(ls[1]), .frame_start(fs[1]));

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(1)
  ) u_duts (
    .clk(clk), .rst_n(rst_n), .vga_clk(vc[2]), .hsync(hs[2]), .vsync(vs[2]),
    .sync_b(sb[2]), .blank_b(bl[2]), .x(x[2]), .y(y[2]),
    .line_start(ls[2]), .frame_start(fs[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {x[g], y[g], hs[g], vs[g], bl[g], ls[g], fs[g], vc[g], sb[g]};
  end

  // Expected outputs of instance k after nn clock edges since reset release.
  function automatic obs_t model(input int k, input int nn);
    obs_t r;
    int ht, vt, p, px, py, q, qx, qy;
    ht = ha[k] + hfp[k] + hsw[k] + hbp[k];
    vt = va[k] + vfp[k] + vsw[k] + vbp[k];
    r = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    r.vc = ((nn % cd[k]) >= cd[k] / 2);
    if (nn < cd[k]) return r;
    p  = nn / cd[k] - 1;
    px = p % ht;
    py = (p / ht) % vt;
    r.x = 10'(px);
    r.y = 10'(py);
    if (nn % cd[k] == 0) begin
      r.ls = (px == 0);
      r.fs = (px == 0) && (py == 0);
    end
    if (p >= dly[k]) begin
      q  = p - dly[k];
      qx = q % ht;
      qy = (q / ht) % vt;
      r.bl = (qx < ha[k]) && (qy < va[k]);
      r.hs = !((qx >= ha[k] + hfp[k]) && (qx < ha[k] + hfp[k] + hsw[k]));
      r.vs = !((qy >= va[k] + vfp[k]) && (qy < va[k] + vfp[k] + vsw[k]));
    end
    return r;
  endfunction

  sb_t q[$];
  int  checks   = 0;
  int  failures = 0;
  int  n        = 0;

  task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Push expectations for the coming edge, clock it, then pop and compare.
  task automatic step();
    sb_t ent;
    for (int k = 0; k < 3; k++) q.push_back('{id: k, e: model(k, n + 1)});
    @(posedge clk);
    n++;
    #1;
    while (q.size() > 0) begin
      ent = q.pop_front();
      check_obs($sformatf("edge dut%0d n=%0d", ent.id, n), obs[ent.id], ent.e);
    end
  endtask

  task automatic check_reset_now(input string tag);
    for (int k = 0; k < 3; k++)
      check_obs($sformatf("%s dut%0d", tag, k), obs[k], model(k, 0));
  endtask

  int hs0_low, hs2_low, vss_low, last_fs, fs_gaps;

  initial begin
    hs0_low = 0; hs2_low = 0; vss_low = 0; last_fs = -1; fs_gaps = 0;

    // Reset state while held.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_now("reset_hold");

    // Release mid-cycle; edge count restarts.
    #2 rst_n = 1'b1;
    n = 0;

    // Line 0 of the default raster and several small-raster frames.
    for (int i = 0; i < 1700; i++) begin
      step();
      if (n >= 2 && n < 1602) begin
        if (hs[0] == 1'b0) hs0_low++;
        if (hs[1] == 1'b0) hs2_low++;
      end
      if (n >= 4 && n < 484 && vs[2] == 1'b0) vss_low++;
      if (fs[2]) begin
        if (last_fs >= 0) begin
          check_int("small_frame_period", n - last_fs, 480);
          fs_gaps++;
        end
        last_fs = n;
      end
    end
    check_int("hsync_low_clks_dly0", hs0_low, 192);
    check_int("hsync_low_clks_dly2", hs2_low, 192);
    check_int("small_vsync_low_clks", vss_low, 120);
    check_int("small_frame_count", fs_gaps, 3);

    // Run to x=300 on line 1 of the default raster.
    while (n < 2 * (800 + 300 + 1)) step();
    check_int("mid_line_x", int'(x[0]), 300);

    // Mid-clock asynchronous reset: outputs must clear with no edge.
    #2 rst_n = 1'b0;
    #1;
    check_reset_now("async_reset");
    @(posedge clk);
    #1;
    check_reset_now("reset_held");

    // Restart behaves like power-up.
    #2 rst_n = 1'b1;
    n = 0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. It produces the pixel coordinates (x, y) and blank_b consumed by the pixel colour generator. It also drives hsync, vsync, sync_b and vga_clk to the video DAC/connector. Frame and line start pulses let the game logic latch board_state once per frame without tearing.

Parameters:
CLK_DIV, 2, system clocks per pixel; must be even and >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DLY, 0, pixel ticks by which hsync/vsync/blank_b lag x/y (range 0..3), matching downstream colour-path latency

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  reset; one clock, asynchronous and active-low
vga_clk  output  1  pixel clock to DAC
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
sync_b  output  1  composite sync to DAC, tied 0
blank_b  output  1  1 = visible region
x  output  10  current pixel column
y  output  10  current pixel row
line_start  output  1  one-clk pulse when x becomes 0
frame_start  output  1  one-clk pulse when (x,y) becomes (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div == CLK_DIV-1), combinational, internal.
  - vga_clk = registered (div_next >= CLK_DIV/2), so its rising edge falls mid-pixel.
- Reset values (asynchronous, immediate): div=0, hcnt=0, vcnt=0, started=0, x=0, y=0, hsync=1, vsync=1, blank_b=0, vga_clk=0, line_start=0, frame_start=0; all delay-stage registers inactive (1,1,0).
- Start-up:
  - First pix_tick after reset release (the CLK_DIV-th edge) presents (0,0) without advancing, and sets started=1.
  - On that edge: blank_b=1 (PIPE_DLY=0), line_start=1, frame_start=1.
- Counting, on each pix_tick with started=1:
  - hcnt = (hcnt == H_TOTAL-1) ? 0 : hcnt+1.
  - On hcnt wrap, vcnt = (vcnt == V_TOTAL-1) ? 0 : vcnt+1.
  - Counters and outputs update on non-tick edges only via the divider.
- Output registers load the decode of the count being entered, on the same edge, so x/y and the undelayed syncs are always consistent:
  - x = hcnt, y = vcnt, full 10-bit width; max values 799 / 524, no truncation.
  - blank_b_raw = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hsync_raw = 0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_raw = 0 iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491), for the entire line.
- Strobes:
  - line_start = 1 for exactly one clk, on the edge loading hcnt=0.
  - frame_start = 1 for exactly one clk, on the edge loading (0,0).
  - Both are low on all other edges, including non-tick edges.
- Delay: hsync, vsync and blank_b pass through PIPE_DLY pixel-tick-enabled stages. With PIPE_DLY=0 they equal the raw decodes; x, y and the strobes are never delayed.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 840000 clk.
- Reset mid-frame: all outputs take reset values within the same cycle, with no clock required. After release, behaviour is identical to start-up, with no partial line.

Decomposition:
- vga_pkg: the default timing constants, derived H_TOTAL/V_TOTAL, sync-window bounds, and the coordinate type (10-bit).
- One sub-module, vga_sync_delay: a parameterised PIPE_DLY-deep, enable-gated shift register for {hsync, vsync, blank_b} with inactive reset value.

Test Plan:
1. Release reset, CLK_DIV=2 -> on 2nd edge x=0, y=0, blank_b=1, hsync=1, frame_start=1 and line_start=1 for one clk; x=1 two edges later.
2. Scan line 0 -> blank_b=1 for x 0..639 and 0 for 640..799; hsync=0 for exactly x 656..751 (96 ticks, 192 clk).
3. Scan y 489..492 -> vsync=0 for all of lines 490 and 491 (1600 ticks) and 1 on 489 and 492; blank_b=0 for all y >= 480.
4. Reach x=799, y=524 -> next tick gives x=0, y=0 and frame_start pulse; consecutive frame_start pulses are 840000 clk apart; x never exceeds 799 and y never exceeds 524.
5. Assert rst_n low mid-clock at x=300, y=200 -> hsync=1, vsync=1, blank_b=0, x=0, y=0 before the next clk edge; after release, the frame restarts per scenario 1.
6. PIPE_DLY=2 -> hsync falls on the 2nd tick after x=656 is presented; blank_b falls 2 ticks after x=640; x/y timing is unchanged versus PIPE_DLY=0.
